// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch path: widths, IR field positions,
// opcode constants and the fetch-state encoding.
package sisc_pkg;

    localparam int PC_W_DEF = 16;
    localparam int IR_W_DEF = 32;
    localparam int IMM_W    = 16;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int MM_MSB     = 27;
    localparam int MM_LSB     = 24;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_BR  = 4'hB;
    localparam logic [3:0] OP_BRZ = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_IO  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection (sequential, absolute or
// PC-relative branch). The immediate always comes from the held IR.
module fetch_pc_gen
    import sisc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             pc_rst,
    input  logic             pc_write,
    input  logic             pc_sel,
    input  logic             br_sel,
    input  logic [IMM_W-1:0] imm,
    output logic [PC_W-1:0]  pc
);

    logic [31:0]     imm_sext32;
    logic [31:0]     imm_zext32;
    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] imm_zext;
    logic [PC_W-1:0] pc_next;

    // Immediates are widened to 32 bits first, then cut to the PC width.
    assign imm_sext32 = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext32 = {{(32-IMM_W){1'b0}}, imm};
    assign imm_sext   = imm_sext32[PC_W-1:0];
    assign imm_zext   = imm_zext32[PC_W-1:0];

    always_comb begin
        pc_next = pc;
        if (!pc_sel) begin
            pc_next = pc + PC_W'(1);
        end else if (br_sel) begin
            pc_next = imm_zext;
        end else begin
            pc_next = pc + imm_sext;
        end
    end

    // A clear request from control outranks any PC write.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            pc <= '0;
        end else if (pc_rst) begin
            pc <= '0;
        end else if (pc_write) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation plus a two-state request/response FSM that
// loads the instruction register from instruction memory.
module fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IR_W = IR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc_out,
    output logic [IR_W-1:0] ir_out,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [15:0]     imm,
    output logic            ir_valid,
    output logic            fetch_busy
);

    fetch_state_t state;

    assign opcode = ir_out[OPCODE_MSB:OPCODE_LSB];
    assign mm     = ir_out[MM_MSB:MM_LSB];
    assign imm    = ir_out[IMM_MSB:IMM_LSB];

    fetch_pc_gen #(
        .PC_W (PC_W)
    ) u_pc_gen (
        .clk      (clk),
        .rst_f    (rst_f),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .imm      (imm),
        .pc       (pc_out)
    );

    // imem_addr is captured once per fetch from the pre-update PC, so PC
    // writes during WAIT never disturb the outstanding request.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state      <= FETCH_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            ir_out     <= '0;
            ir_valid   <= 1'b0;
            fetch_busy <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (ir_load) begin
                        imem_addr  <= pc_out;
                        imem_req   <= 1'b1;
                        ir_valid   <= 1'b0;
                        fetch_busy <= 1'b1;
                        state      <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_valid) begin
                        ir_out     <= imem_rdata;
                        ir_valid   <= 1'b1;
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                        state      <= FETCH_IDLE;
                    end
                end
                default: begin
                    imem_req   <= 1'b0;
                    fetch_busy <= 1'b0;
                    state      <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch latency, PC arithmetic,
// branch source and simultaneous fetch/PC-update behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        rst_f;
    logic        pc_rst;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic        ir_load;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_out;
    logic [31:0] ir_out;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic        ir_valid;
    logic        fetch_busy;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .PC_W (16),
        .IR_W (32)
    ) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc_out     (pc_out),
        .ir_out     (ir_out),
        .opcode     (opcode),
        .mm         (mm),
        .imm        (imm),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Minimum-latency fetch: ir_load on one edge, imem_valid on the next.
    task automatic do_fetch(input logic [31:0] data);
        ir_load = 1'b1;
        tick();
        ir_load    = 1'b0;
        imem_rdata = data;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
    endtask

    task automatic do_pc_write(input logic sel, input logic br);
        pc_write = 1'b1;
        pc_sel   = sel;
        br_sel   = br;
        tick();
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
    endtask

    initial begin
        rst_f      = 1'b0;
        pc_rst     = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        ir_load    = 1'b0;
        imem_rdata = 32'h0;
        imem_valid = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst_f = 1'b1;
        #1;
        check_output("rst_pc",    32'(pc_out),     32'h0);
        check_output("rst_ir",    ir_out,          32'h0);
        check_output("rst_addr",  32'(imem_addr),  32'h0);
        check_output("rst_req",   32'(imem_req),   32'h0);
        check_output("rst_valid", 32'(ir_valid),   32'h0);
        check_output("rst_busy",  32'(fetch_busy), 32'h0);
        tick();
        tick();
        rst_f = 1'b0;

        // Reset mid-WAIT abandons the fetch; later imem_valid ignored
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check_output("mw_req",  32'(imem_req),   32'h1);
        check_output("mw_busy", 32'(fetch_busy), 32'h1);
        check_output("mw_addr", 32'(imem_addr),  32'h0);
        tick();
        #2 rst_f = 1'b1;
        #1;
        check_output("mw_rst_req",  32'(imem_req),   32'h0);
        check_output("mw_rst_busy", 32'(fetch_busy), 32'h0);
        rst_f      = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        check_output("mw_ir_ignored",    ir_out,        32'h0);
        check_output("mw_valid_ignored", 32'(ir_valid), 32'h0);
        check_output("mw_idle_req",      32'(imem_req), 32'h0);

        // Fetch with imem_valid three cycles after ir_load
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check_output("lat_busy1", 32'(fetch_busy), 32'h1);
        tick();
        check_output("lat_busy2", 32'(fetch_busy), 32'h1);
        check_output("lat_valid_lo", 32'(ir_valid), 32'h0);
        tick();
        check_output("lat_busy3", 32'(fetch_busy), 32'h1);
        imem_rdata = 32'h8812_0005;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        check_output("lat_valid",  32'(ir_valid),   32'h1);
        check_output("lat_ir",     ir_out,          32'h8812_0005);
        check_output("lat_opcode", 32'(opcode),     32'h8);
        check_output("lat_mm",     32'(mm),         32'h8);
        check_output("lat_imm",    32'(imm),        32'h0005);
        check_output("lat_busy0",  32'(fetch_busy), 32'h0);
        check_output("lat_req0",   32'(imem_req),   32'h0);

        // New fetch clears ir_valid while in flight
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check_output("refetch_valid_clr", 32'(ir_valid), 32'h0);
        imem_rdata = 32'h1000_FFFF;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        check_output("refetch_imm", 32'(imm), 32'hFFFF);

        // Absolute branch to 0xFFFF, then sequential wrap
        do_pc_write(1'b1, 1'b1);
        check_output("abs_ffff", 32'(pc_out), 32'hFFFF);
        tick();
        check_output("pc_hold", 32'(pc_out), 32'hFFFF);
        do_pc_write(1'b0, 1'b0);
        check_output("wrap", 32'(pc_out), 32'h0000);

        // Relative branch backwards by 2 from 0x0010
        do_fetch(32'hB000_0010);
        do_pc_write(1'b1, 1'b1);
        check_output("abs_0010", 32'(pc_out), 32'h0010);
        do_fetch(32'hB000_FFFE);
        do_pc_write(1'b1, 1'b0);
        check_output("rel_neg2", 32'(pc_out), 32'h000E);
        do_fetch(32'hD000_0040);
        do_pc_write(1'b1, 1'b1);
        check_output("abs_0040", 32'(pc_out), 32'h0040);

        // Branch on the completing edge uses the held IR, not imem_rdata
        ir_load = 1'b1;
        tick();
        ir_load    = 1'b0;
        imem_rdata = 32'h0000_0100;
        imem_valid = 1'b1;
        pc_write   = 1'b1;
        pc_sel     = 1'b1;
        br_sel     = 1'b0;
        tick();
        imem_valid = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        check_output("br_held_ir", 32'(pc_out), 32'h0080);
        check_output("br_new_ir",  ir_out,      32'h0000_0100);

        // pc_rst outranks pc_write
        do_fetch(32'hB000_0020);
        do_pc_write(1'b1, 1'b1);
        check_output("abs_0020", 32'(pc_out), 32'h0020);
        pc_rst = 1'b1;
        do_pc_write(1'b0, 1'b0);
        pc_rst = 1'b0;
        check_output("prio_rst", 32'(pc_out), 32'h0000);

        // Simultaneous ir_load and pc_write at PC=5
        do_fetch(32'hB000_0005);
        do_pc_write(1'b1, 1'b1);
        check_output("abs_0005", 32'(pc_out), 32'h0005);
        ir_load  = 1'b1;
        pc_write = 1'b1;
        tick();
        check_output("sim_addr", 32'(imem_addr),  32'h0005);
        check_output("sim_pc",   32'(pc_out),     32'h0006);
        check_output("sim_busy", 32'(fetch_busy), 32'h1);
        tick();
        ir_load  = 1'b0;
        pc_write = 1'b0;
        check_output("wait_ld_addr", 32'(imem_addr),  32'h0005);
        check_output("wait_ld_pc",   32'(pc_out),     32'h0007);
        check_output("wait_ld_busy", 32'(fetch_busy), 32'h1);
        imem_rdata = 32'h2300_1234;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        check_output("sim_ir",    ir_out,          32'h2300_1234);
        check_output("sim_done",  32'(fetch_busy), 32'h0);
        tick();
        check_output("no_queued_fetch", 32'(imem_req), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, default 16, program-counter and instruction-address width.
REQ-002 Parameter: IR_W, default 32, instruction width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_f  input  1  asynchronous, active-high reset; asserting it immediately forces reset state regardless of clk.
REQ-005 Port: pc_rst  input  1  synchronous PC clear request from control FSM.
REQ-006 Port: pc_write  input  1  PC update enable.
REQ-007 Port: pc_sel  input  1  0 = sequential (PC+1), 1 = branch target.
REQ-008 Port: br_sel  input  1  branch mode when pc_sel=1: 1 = absolute, 0 = PC-relative.
REQ-009 Port: ir_load  input  1  one-cycle request to fetch the instruction at the current PC into the IR.
REQ-010 Port: imem_rdata  input  IR_W  instruction memory read data.
REQ-011 Port: imem_valid  input  1  imem_rdata valid this cycle.
REQ-012 Port: imem_req  output  1  read request to instruction memory, held until accepted.
REQ-013 Port: imem_addr  output  PC_W  read address; stable while imem_req=1.
REQ-014 Port: pc_out  output  PC_W  current PC.
REQ-015 Port: ir_out  output  IR_W  instruction register.
REQ-016 Port: opcode  output  4  ir_out[31:28], to control FSM.
REQ-017 Port: mm  output  4  ir_out[27:24], to control FSM.
REQ-018 Port: imm  output  16  ir_out[15:0].
REQ-019 Port: ir_valid  output  1  ir_out holds a completed fetch.
REQ-020 Port: fetch_busy  output  1  a fetch is in flight.

Function
REQ-021 Fetch FSM shall have states IDLE and WAIT; reset enters IDLE.
REQ-022 In IDLE, ir_load=1 shall latch imem_addr<=pc_out, set imem_req=1, clear ir_valid, and enter WAIT on the same edge.
REQ-023 In WAIT, imem_valid=1 shall load ir_out<=imem_rdata, set ir_valid=1, clear imem_req, return to IDLE; minimum fetch latency is 2 edges from ir_load.
REQ-024 In WAIT, imem_valid=0 shall hold all fetch state; no timeout.
REQ-025 ir_load in WAIT shall be ignored (not queued); fetch_busy=1 exactly in WAIT.
REQ-026 imem_valid in IDLE shall be ignored; ir_out unchanged.
REQ-027 PC update priority: pc_rst (PC<=0) over pc_write; neither -> PC holds.
REQ-028 pc_write with pc_sel=0 shall set PC<=PC+1 modulo 2^PC_W (0xFFFF -> 0x0000).
REQ-029 pc_write, pc_sel=1, br_sel=1 shall set PC<=imm.
REQ-030 pc_write, pc_sel=1, br_sel=0 shall set PC<=PC+sign-extended imm, modulo 2^PC_W.
REQ-031 Branch target shall use ir_out as held at that edge, never in-flight imem_rdata.
REQ-032 PC updates are legal in any fetch state; an in-flight imem_addr shall not change.
REQ-033 ir_load and pc_write on the same edge: fetch uses the pre-update PC.
REQ-034 opcode, mm, imm shall be combinational slices of ir_out.

Reset
REQ-035 rst_f=1 shall force PC=0, ir_out=0, imem_addr=0, imem_req=0, ir_valid=0, state IDLE, asynchronously.
REQ-036 rst_f during WAIT shall abandon the fetch; a later imem_valid shall be ignored.
REQ-037 First rising edge after rst_f deasserts shall be processed normally.

Structure
REQ-038 Shared package sisc_pkg shall hold opcode constants, IR field positions, PC_W/IR_W defaults, fetch-state enum.
REQ-039 Next-PC mux and PC register shall be sub-module fetch_pc_gen; FSM and IR remain in fetch_unit.

Verification
REQ-040 Reset mid-WAIT: ir_load at PC=0, assert rst_f before imem_valid -> imem_req=0, state IDLE, later imem_valid ignored, ir_out=0.
REQ-041 Fetch latency: ir_load, imem_valid 3 cycles later with 0x8_8_12_0005 -> ir_valid=1 after that edge, opcode=8, mm=8, imm=0x0005, fetch_busy=1 for 3 cycles.
REQ-042 Wrap: PC=0xFFFF, pc_write, pc_sel=0 -> PC=0x0000.
REQ-043 Branches: PC=0x0010, imm=0xFFFE, relative -> PC=0x000E; absolute with imm=0x0040 -> PC=0x0040.
REQ-044 Simultaneous: PC=5, ir_load+pc_write+pc_sel=0 -> imem_addr=5, pc_out=6; second ir_load during WAIT ignored.
REQ-045 Priority: pc_rst and pc_write together at PC=0x0020 -> PC=0x0000.
